// File: rtl/fu_mult_sequencer.sv
// Shift-and-add multiply sequencer that drives an external combinational function unit.
// Optional build macro MULT_ZERO_SKIP_EN: zero operands finish in one cycle without FU operations.
module fu_mult_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [3:0]         fu_FS,
  output logic [WIDTH-1:0]   fu_A,
  output logic [WIDTH-1:0]   fu_B,
  input  logic [WIDTH-1:0]   fu_result,
  input  logic               fu_C
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] FS_XFER = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SHR  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   m_reg, m_nxt;
  logic [WIDTH-1:0]   p_reg, p_nxt;
  logic [WIDTH-1:0]   q_reg, q_nxt;
  logic               cy_reg, cy_nxt;
  logic [CNT_W-1:0]   cnt_reg, cnt_nxt;
  logic [2*WIDTH-1:0] product_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      m_reg   <= '0;
      p_reg   <= '0;
      q_reg   <= '0;
      cy_reg  <= 1'b0;
      cnt_reg <= '0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      m_reg   <= m_nxt;
      p_reg   <= p_nxt;
      q_reg   <= q_nxt;
      cy_reg  <= cy_nxt;
      cnt_reg <= cnt_nxt;
      product <= product_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    m_nxt       = m_reg;
    p_nxt       = p_reg;
    q_nxt       = q_reg;
    cy_nxt      = cy_reg;
    cnt_nxt     = cnt_reg;
    product_nxt = product;
    fu_FS       = FS_XFER;
    fu_A        = '0;
    fu_B        = '0;
    busy        = 1'b1;
    done        = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          m_nxt     = mcand;
          q_nxt     = mplier;
          p_nxt     = '0;
          cy_nxt    = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_ADD;
`ifdef MULT_ZERO_SKIP_EN
          if ((mcand == '0) || (mplier == '0)) begin
            q_nxt       = '0;
            product_nxt = '0;
            state_nxt   = S_DONE;
          end
`endif
        end
      end

      // A+0 with carry 0 when the multiplier bit is clear keeps the FU path uniform.
      S_ADD: begin
        fu_A      = p_reg;
        fu_B      = m_reg;
        fu_FS     = q_reg[0] ? FS_ADD : FS_XFER;
        p_nxt     = fu_result;
        cy_nxt    = fu_C;
        state_nxt = S_SHIFT;
      end

      // The FU shifts P right; the latched carry refills its top bit and P[0] moves into Q.
      S_SHIFT: begin
        fu_FS  = FS_SHR;
        fu_B   = p_reg;
        p_nxt  = {cy_reg, fu_result[WIDTH-2:0]};
        q_nxt  = {p_reg[0], q_reg[WIDTH-1:1]};
        cy_nxt = 1'b0;
        if (cnt_reg == CNT_LAST) begin
          product_nxt = {p_nxt, q_nxt};
          state_nxt   = S_DONE;
        end else begin
          cnt_nxt   = cnt_reg + 1'b1;
          state_nxt = S_ADD;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fu_mult_sequencer.sv
// Scoreboard bench for fu_mult_sequencer with a behavioural combinational function unit.
module tb_fu_mult_sequencer;

  localparam int W = 16;

  logic           clock;
  logic           reset;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [3:0]     fu_FS;
  logic [W-1:0]   fu_A;
  logic [W-1:0]   fu_B;
  logic [W-1:0]   fu_result;
  logic           fu_C;

  int passed = 0;
  int total  = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_prod;

`ifdef MULT_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  fu_mult_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product), .fu_FS(fu_FS), .fu_A(fu_A),
    .fu_B(fu_B), .fu_result(fu_result), .fu_C(fu_C)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Function unit model: transfer, add, shift right of B.
  always_comb begin
    fu_result = '0;
    fu_C      = 1'b0;
    case (fu_FS)
      4'b0000: fu_result = fu_A;
      4'b0010: {fu_C, fu_result} = {1'b0, fu_A} + {1'b0, fu_B};
      4'b1101: fu_result = fu_B >> 1;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("product", 64'(product), 64'(exp_q.pop_front()));
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_prod, input int exp_lat, input bit all_add);
    int lat;
    int busy_err;
    int fs_err;
    int hold_err;
    mcand = a;
    mplier = b;
    start = 1'b1;
    exp_q.push_back(exp_prod);
    @(posedge clock); #1;
    start = 1'b0;
    mcand = 16'($urandom);
    mplier = 16'($urandom);
    lat = 1; busy_err = 0; fs_err = 0; hold_err = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_err++;
      if (product !== last_prod) hold_err++;
      if (lat % 2 == 0) begin
        if (fu_FS !== 4'b1101) fs_err++;
      end else if (all_add) begin
        if (fu_FS !== 4'b0010) fs_err++;
      end else if (fu_FS !== 4'b0010 && fu_FS !== 4'b0000) fs_err++;
      @(posedge clock); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_err"}, 64'(busy_err), 64'd0);
    check({name, "_fs_err"}, 64'(fs_err), 64'd0);
    check({name, "_hold_err"}, 64'(hold_err), 64'd0);
    check({name, "_busy_at_done"}, 64'(busy), 64'd1);
    @(posedge clock); #1;
    check({name, "_idle_done"}, 64'(done), 64'd0);
    check({name, "_idle_busy"}, 64'(busy), 64'd0);
    check({name, "_held"}, 64'(product), 64'(exp_prod));
    last_prod = exp_prod;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0; last_prod = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_fs", 64'(fu_FS), 64'd0);
    check("rst_fu_a", 64'(fu_A), 64'd0);
    check("rst_fu_b", 64'(fu_B), 64'd0);

    // reset together with start: start ignored
    start = 1'b1; mcand = 16'd3; mplier = 16'd3;
    @(posedge clock); #1;
    check("rst_start_busy", 64'(busy), 64'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clock); #1;

    run_op("basic_3x5", 16'd3, 16'd5, 32'h0000000F, 33, 1'b0);
    run_op("carry_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 33, 1'b1);
    run_op("abcd_1234", 16'hABCD, 16'h1234, 32'h0C374FA4, 33, 1'b0);

    // start held high: second acceptance only at the edge ending cycle 34
    mcand = 16'd7; mplier = 16'd9; start = 1'b1;
    exp_q.push_back(32'd63);
    @(posedge clock); #1;
    lat = 1;
    while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
    check("held_start_latency", 64'(lat), 64'd33);
    @(posedge clock); #1;
    check("held_start_idle_c34", 64'(busy), 64'd0);
    exp_q.push_back(32'd63);
    @(posedge clock); #1;
    check("held_start_busy_c35", 64'(busy), 64'd1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
    check("held_start_latency2", 64'(lat), 64'd33);
    @(posedge clock); #1;
    last_prod = 32'd63;

    // reset during cycle 10 discards the operation
    mcand = 16'h1234; mplier = 16'h0100; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    repeat (30) begin @(posedge clock); #1; end
    check("midrst_still_idle", 64'(busy), 64'd0);
    last_prod = '0;
    run_op("after_rst", 16'h1234, 16'h0100, 32'h00123400, 33, 1'b0);

    run_op("ff_x_101", 16'h00FF, 16'h0101, 32'h0000FFFF, 33, 1'b0);
    run_op("hold_2x2", 16'd2, 16'd2, 32'h00000004, 33, 1'b0);
    run_op("zero_mcand", 16'h0000, 16'hABCD, 32'h00000000, ZERO_LAT, 1'b0);
    run_op("after_zero", 16'd6, 16'd7, 32'd42, 33, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fu_mult_sequencer.md
# fu_mult_sequencer

Multi-cycle unsigned multiply controller for the Simple Computer function unit. It accepts two WIDTH-bit operands through a start/busy/done handshake. It forms the 2·WIDTH-bit product by shift-and-add, issuing one function-unit operation per cycle: add through the arithmetic path, shift through the SHR path. The block owns the function unit's FS/A/B inputs while busy and consumes its result and carry-out.

## Interface
- WIDTH, 16, operand width; must equal the function unit width.
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start  in  1  request; sampled only in IDLE.
- mcand  in  WIDTH  multiplicand; captured on the accepting edge.
- mplier  in  WIDTH  multiplier; captured on the accepting edge.
- busy  out  1  high from ADD through DONE inclusive.
- done  out  1  one-cycle pulse; product valid.
- product  out  2·WIDTH  {P, Q} result; held until the next accepted start or reset.
- fu_FS  out  4  function unit select code.
- fu_A  out  WIDTH  function unit operand A.
- fu_B  out  WIDTH  function unit operand B.
- fu_result  in  WIDTH  function unit result.
- fu_C  in  1  function unit carry-out.

## Operation
- Registers:
  - M: multiplicand.
  - P: upper product half.
  - Q: multiplier / lower half.
  - cy: latched carry.
  - cnt: log2(WIDTH) bits.
  - state: IDLE, ADD, SHIFT, DONE.
- Reset values: state=IDLE, M=P=Q=0, cy=0, cnt=0, busy=0, done=0, product=0, fu_FS=4'b0000, fu_A=0, fu_B=0.
- **IDLE**
  - fu_FS=0000 (transfer A); fu_A=0; fu_B=0.
  - On start=1: M←mcand, Q←mplier, P←0, cy←0, cnt←0; go to ADD.
- **ADD**
  - fu_A=P, fu_B=M.
  - fu_FS=0010 (A+B) when Q[0]=1; otherwise 0000 (A+0, carry 0).
  - Latch P←fu_result and cy←fu_C; go to SHIFT.
- **SHIFT**
  - fu_FS=1101 (SHR), fu_B=P, fu_A=0.
  - Latch P←{cy, fu_result[WIDTH-2:0]}, Q←{P[0], Q[WIDTH-1:1]}, cy←0.
  - If cnt=WIDTH-1, go to DONE; otherwise cnt←cnt+1 and go to ADD.
- **DONE**
  - done=1; product={P,Q}; go to IDLE.
- FU outputs are combinational from state and registers; no added latency. The FU is combinational, so results are consumed in the same cycle.
- start while busy (including DONE) is ignored and not queued.
- mcand and mplier are don't-care except on the accepting edge.
- The product is exact modulo 2^(2·WIDTH); overflow is impossible.
- Status flags V, N, Z from the function unit are unused.

## Timing
- Let edge 0 be the edge that samples start=1 in IDLE.
- Cycles 1..2·WIDTH alternate ADD, SHIFT.
- Cycle 2·WIDTH+1 is DONE: done=1 and product valid. That is cycle 33 for WIDTH=16.
- The earliest next acceptance is the edge ending cycle 2·WIDTH+2, with IDLE entered after DONE.
- product updates only on the DONE-entering edge, or is cleared by reset. It is stable otherwise, including throughout a later operation until that operation's DONE.
- reset asserted in any state wins over every other transition at that edge:
  - state=IDLE, busy=0, done=0, product=0.
  - The partial result is discarded and no done is issued.
- reset and start together: reset wins and start is ignored.
- cnt wrap: the increment from WIDTH-1 never occurs; DONE is taken instead.

## Configuration
- MULT_ZERO_SKIP_EN defined:
  - On acceptance, if mcand==0 or mplier==0, go directly to DONE with P←0, Q←0.
  - done=1 in cycle 1, product=0, and no FU operations are issued.
- Undefined: every operation takes the full 2·WIDTH+1 cycles, including zero operands.

## Test plan
- Basic multiply: start with mcand=3, mplier=5 → busy in cycles 1..33, done pulse in cycle 33 only, product=32'h0000000F.
- Carry path: mcand=16'hFFFF, mplier=16'hFFFF → product=32'hFFFE0001.
  - fu_FS alternates 0010 and 1101 for all 16 iterations.
- Ignored start: start held high continuously from edge 0 with mcand=7, mplier=9 → product=63 at cycle 33.
  - The next acceptance occurs at the edge ending cycle 34, not earlier.
- Reset mid-operation: after mcand=16'h1234, mplier=16'h0100, assert reset during cycle 10 → next cycle state IDLE, busy=0, product=0, no done.
  - A new start afterwards yields the correct product.
- Product hold: after 16'h00FF×16'h0101=32'h0000FFFF, start 2×2 → product stays 32'h0000FFFF until that operation's DONE, then becomes 4.
- Zero skip: mcand=0, mplier=16'hABCD.
  - With MULT_ZERO_SKIP_EN: done in cycle 1, product=0.
  - Without: done in cycle 33, product=0.
